// File: rtl/ram_read_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_read_streamer_pkg
// Description : Shared definitions for the RAM read streamer: FSM state
//               encodings, default output-buffer depth and the helper that
//               sizes occupancy counters.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_read_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_fifo
// Description : Synchronous FIFO buffering RAM read data for the output
//               stream. head_data always shows the oldest entry. When
//               RAM_READ_STREAMER_LAST_EN is defined each entry carries an
//               extra end-of-burst bit.
// Ports       : clk, rst_n          - clock, async active-low reset
//               push, push_data     - write one entry
//               push_last           - end-of-burst bit (LAST_EN only)
//               pop                 - discard head entry
//               head_data           - head entry data
//               head_last           - head end-of-burst bit (LAST_EN only)
//               count               - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_fifo
  import ram_read_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       push_data,
`ifdef RAM_READ_STREAMER_LAST_EN
  input  logic                        push_last,
  output logic                        head_last,
`endif
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       head_data,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

`ifdef RAM_READ_STREAMER_LAST_EN
  logic last_mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (push) last_mem[wr_ptr] <= push_last;
  end

  assign head_last = last_mem[rd_ptr];
`endif

endmodule
`default_nettype wire

// File: rtl/ram_read_streamer.sv
`default_nettype none
// ============================================================================
// Module      : ram_read_streamer
// Description : Issues a burst of consecutive reads to a registered-read RAM,
//               absorbs its one-cycle latency and streams the words out over
//               valid/ready through a small FIFO. Reads are only issued when
//               the FIFO has room for every read already in flight, so data
//               is never dropped under backpressure.
//               Optional macro RAM_READ_STREAMER_LAST_EN adds Last________o.
// Ports       : Clock_______i, Resetn______i    - clock, async active-low reset
//               Start_______i, Base_addr___i,
//               Length______i                   - burst request
//               Busy________o, Done________o    - burst status
//               Read_enable_o, Read_addr___o,
//               Ram_data____i                   - RAM read port
//               Data_valid__o, Data_ready__i,
//               Data________o, Last________o    - output stream
// Revision    : 1.0 - initial release
// ============================================================================
module ram_read_streamer
  import ram_read_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  Clock_______i,
  input  logic                  Resetn______i,
  input  logic                  Start_______i,
  input  logic [ADDR_WIDTH-1:0] Base_addr___i,
  input  logic [ADDR_WIDTH:0]   Length______i,
  output logic                  Busy________o,
  output logic                  Done________o,
  output logic                  Read_enable_o,
  output logic [ADDR_WIDTH-1:0] Read_addr___o,
  input  logic [DATA_WIDTH-1:0] Ram_data____i,
  output logic                  Data_valid__o,
  input  logic                  Data_ready__i,
  output logic [DATA_WIDTH-1:0] Data________o
`ifdef RAM_READ_STREAMER_LAST_EN
  ,
  output logic                  Last________o
`endif
);

  localparam int                CW      = cnt_width(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH:0]     remaining;
  logic                    push_pending;   // RAM data arriving this cycle
  logic [CW-1:0]           fifo_count;
  logic [DATA_WIDTH-1:0]   head_data;
  logic [31:0]             committed;
  logic                    room;
  logic                    start_go;
  logic                    start_burst;
  logic                    issue;
  logic                    pop;
  logic                    drain_done;

  assign Data_valid__o = (fifo_count != '0);
  assign pop           = Data_valid__o & Data_ready__i;
  assign Data________o = Data_valid__o ? head_data : '0;

  // Entries stored plus reads whose data has not yet landed in the FIFO.
  assign committed   = 32'(fifo_count) + 32'(Read_enable_o) + 32'(push_pending);
  assign room        = committed < 32'(FIFO_DEPTH);
  assign start_go    = (state == ST_IDLE) && Start_______i;
  assign start_burst = start_go && (Length______i != '0);
  assign issue       = (state == ST_ISSUE) && (remaining != '0) && room;
  // Last word leaves in this cycle, or nothing is left anywhere.
  assign drain_done  = !Read_enable_o && !push_pending &&
                       ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clock_______i or negedge Resetn______i) begin
    if (!Resetn______i) state <= ST_IDLE;
    else                state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_go) state_next = start_burst ? ST_ISSUE : ST_DONE;
      ST_ISSUE: if ((remaining == '0) || (issue && (remaining == LEN_ONE)))
                  state_next = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    Busy________o = 1'b0;
    Done________o = 1'b0;
    case (state)
      ST_ISSUE, ST_DRAIN: Busy________o = 1'b1;
      ST_DONE:            Done________o = 1'b1;
      default:            ;
    endcase
  end

  // ---------------- Read issue datapath ----------------
  // The first read is launched straight from IDLE so the RAM sees it in the
  // cycle right after Start.
  always_ff @(posedge Clock_______i or negedge Resetn______i) begin
    if (!Resetn______i) begin
      Read_enable_o <= 1'b0;
      Read_addr___o <= '0;
      remaining     <= '0;
      push_pending  <= 1'b0;
    end else begin
      Read_enable_o <= 1'b0;
      push_pending  <= Read_enable_o;
      if (start_burst) begin
        Read_enable_o <= 1'b1;
        Read_addr___o <= Base_addr___i;
        remaining     <= Length______i - LEN_ONE;
      end else if (issue) begin
        Read_enable_o <= 1'b1;
        Read_addr___o <= Read_addr___o + ADDR_WIDTH'(1);
        remaining     <= remaining - LEN_ONE;
      end
    end
  end

`ifdef RAM_READ_STREAMER_LAST_EN
  logic read_last;
  logic push_last;
  logic head_last;

  // End-of-burst flag travels alongside the read through the RAM latency.
  always_ff @(posedge Clock_______i or negedge Resetn______i) begin
    if (!Resetn______i) begin
      read_last <= 1'b0;
      push_last <= 1'b0;
    end else begin
      read_last <= 1'b0;
      push_last <= read_last;
      if (start_burst)  read_last <= (Length______i == LEN_ONE);
      else if (issue)   read_last <= (remaining == LEN_ONE);
    end
  end

  assign Last________o = Data_valid__o & head_last;
`endif

  ram_stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clock_______i),
    .rst_n     (Resetn______i),
    .push      (push_pending),
    .push_data (Ram_data____i),
`ifdef RAM_READ_STREAMER_LAST_EN
    .push_last (push_last),
    .head_last (head_last),
`endif
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count)
  );

endmodule
`default_nettype wire
